// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined carry-save multiplier.
package mult_pkg;

    localparam int MAX_WIDTH = 32;

    // Payload carried by each reduction stage; sized for the widest legal operand.
    typedef struct packed {
        logic [2*MAX_WIDTH-1:0] sum;
        logic [2*MAX_WIDTH-1:0] carry;
        logic [MAX_WIDTH-1:0]   a;
        logic [MAX_WIDTH-1:0]   b;
        logic                   is_signed;
        logic                   valid;
    } stage_t;

    function automatic int mult_latency(input int width, input int rows);
        return (width + rows - 1) / rows + 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// One row of full adders: folds a gated partial-product row into a (sum, carry) pair.
// The carry output has weight 2, so the pair's value is sum + (carry << 1).
module csa_row #(
    parameter int WIDTH = 8,
    parameter int ROW   = 0
) (
    input  logic [WIDTH-1:0]   a,
    input  logic               b_bit,
    input  logic               is_signed,
    input  logic [2*WIDTH-1:0] sum_in,
    input  logic [2*WIDTH-2:0] carry_in,
    output logic [2*WIDTH-1:0] sum_out,
    output logic [2*WIDTH-1:0] carry_out
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] pp;
    logic [PW-1:0]    pp_ext;
    logic [PW-1:0]    carry_sh;

    // NOTE: pp gets its full default before the conditional inversions, so no latch can form.
    always_comb begin
        pp = a & {WIDTH{b_bit}};
        if (is_signed) begin
            // Baugh-Wooley: complement the sign-crossing terms, keep the sign*sign term.
            if (ROW < WIDTH - 1) pp[WIDTH-1]   = ~pp[WIDTH-1];
            else                 pp[WIDTH-2:0] = ~pp[WIDTH-2:0];
        end
    end

    assign pp_ext    = PW'(pp) << ROW;
    assign carry_sh  = {carry_in, 1'b0};
    assign sum_out   = sum_in ^ carry_sh ^ pp_ext;
    assign carry_out = (sum_in & carry_sh) | (sum_in & pp_ext) | (carry_sh & pp_ext);

endmodule

// File: rtl/pipelined_mult.sv
// WIDTH x WIDTH signed/unsigned multiplier: registered carry-save reduction stages,
// a final carry-propagate stage, and a valid/ready handshake with global stall.
module pipelined_mult
    import mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_signed
);
    localparam int LATENCY    = mult_latency(WIDTH, ROWS_PER_STAGE);
    localparam int NUM_STAGES = LATENCY - 1;
    localparam int PW         = 2 * WIDTH;
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    logic   adv;
    stage_t stage_q [NUM_STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [PW-1:0]    s_chain [ROWS_PER_STAGE+1];
        logic [PW-1:0]    c_chain [ROWS_PER_STAGE+1];
        logic [WIDTH-1:0] a_cur;
        logic [WIDTH-1:0] b_cur;
        logic             sgn_cur;
        logic             vld_cur;
        stage_t           d;
        logic             unused_bits;

        if (k == 0) begin : g_head
            assign a_cur      = in_a;
            assign b_cur      = in_b;
            assign sgn_cur    = in_signed;
            assign vld_cur    = in_valid && in_ready;
            assign s_chain[0] = in_signed ? BW_CONST : '0;
            assign c_chain[0] = '0;
        end else begin : g_body
            assign a_cur      = stage_q[k-1].a[WIDTH-1:0];
            assign b_cur      = stage_q[k-1].b[WIDTH-1:0];
            assign sgn_cur    = stage_q[k-1].is_signed;
            assign vld_cur    = stage_q[k-1].valid;
            assign s_chain[0] = stage_q[k-1].sum[PW-1:0];
            assign c_chain[0] = stage_q[k-1].carry[PW-1:0];
        end

        // Rows past WIDTH in a short final stage pass the pair through untouched.
        for (genvar r = 0; r < ROWS_PER_STAGE; r++) begin : g_row
            if (k * ROWS_PER_STAGE + r < WIDTH) begin : g_fa
                csa_row #(
                    .WIDTH (WIDTH),
                    .ROW   (k * ROWS_PER_STAGE + r)
                ) u_row (
                    .a         (a_cur),
                    .b_bit     (b_cur[r]),
                    .is_signed (sgn_cur),
                    .sum_in    (s_chain[r]),
                    .carry_in  (c_chain[r][PW-2:0]),
                    .sum_out   (s_chain[r+1]),
                    .carry_out (c_chain[r+1])
                );
            end else begin : g_pass
                assign s_chain[r+1] = s_chain[r];
                assign c_chain[r+1] = c_chain[r];
            end
        end

        always_comb begin
            d                = '0;
            d.sum[PW-1:0]    = s_chain[ROWS_PER_STAGE];
            d.carry[PW-1:0]  = c_chain[ROWS_PER_STAGE];
            d.a[WIDTH-1:0]   = a_cur;
            d.b[WIDTH-1:0]   = b_cur >> ROWS_PER_STAGE;
            d.is_signed      = sgn_cur;
            d.valid          = vld_cur;
        end

        // NOTE: the whole payload is reset, not just valid, so every bit lives in one
        // async-reset process; state updates use non-blocking assignments throughout.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)      stage_q[k] <= '0;
            else if (adv) stage_q[k] <= d;
        end

        // Payload bits above this instance's width are constant zero.
        assign unused_bits = ^stage_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_p      <= '0;
            out_signed <= 1'b0;
        end else if (adv) begin
            out_valid  <= stage_q[NUM_STAGES-1].valid;
            out_signed <= stage_q[NUM_STAGES-1].is_signed;
            out_p      <= stage_q[NUM_STAGES-1].sum[PW-1:0]
                        + {stage_q[NUM_STAGES-1].carry[PW-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_pipelined_mult.sv
// Scoreboard bench: directed 8x8 vectors, backpressure and async reset on one instance,
// plus a randomised sweep over several WIDTH / ROWS_PER_STAGE combinations.
module tb_pipelined_mult;

    localparam int LAT = 5;   // ceil(8/2)+1 for the main instance

    typedef struct {
        logic [63:0] p;
        logic        s;
        int          cyc;
        logic        lat;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        sweep_rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        out_signed;

    logic [63:0] exp_p;
    logic        bp_phase;
    logic        stall_prev;
    logic [15:0] held_p;
    logic        held_s;
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    int          sweep_done = 0;
    sb_t         exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    pipelined_mult #(.WIDTH(8), .ROWS_PER_STAGE(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_signed  (in_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_signed (out_signed)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int w);
        longint xa;
        longint xb;
        xa = longint'(a);
        xb = longint'(b);
        if (s && a[w-1]) xa -= longint'(64'd1 << w);
        if (s && b[w-1]) xb -= longint'(64'd1 << w);
        return 64'(xa * xb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [31:0] pick(input int w);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return (32'd1 << w) - 32'd1;
            2:       return 32'd1 << (w - 1);
            default: return $urandom & ((32'd1 << w) - 32'd1);
        endcase
    endfunction

    // Present one operand pair from posedge+1 until accepted, then release.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] p);
        bit ok = 1'b0;
        in_a = a; in_b = b; in_signed = s; exp_p = 64'(p); in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Stimulus side of the scoreboard: record every accepted transaction.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            exp_q.push_back('{exp_p, in_signed, cycle, !bp_phase});
    end

    // Monitor: compare every emitted product against the head of the queue.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_out_valid", 64'(out_valid), 1);
                check("hold_out_p", 64'(out_p), 64'(held_p));
                check("hold_out_signed", 64'(out_signed), 64'(held_s));
            end
            if (out_valid && !out_ready) check("in_ready_drop", 64'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got %0h, expected no output", out_p);
                end else begin
                    check("product", 64'(out_p), exp_q[0].p);
                    check("out_signed", 64'(out_signed), 64'(exp_q[0].s));
                    if (exp_q[0].lat) check("latency", 64'(cycle - exp_q[0].cyc), LAT);
                    exp_q.delete(0);
                end
            end
            stall_prev <= out_valid && !out_ready;
            held_p     <= out_p;
            held_s     <= out_signed;
        end
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
        out_ready = 1'b1; exp_p = '0; bp_phase = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 0);
        check("reset_out_p", 64'(out_p), 0);
        check("reset_out_signed", 64'(out_signed), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("reset_in_ready", 64'(in_ready), 1);
        @(posedge clk); #1;

        send(8'h92, 8'h17, 1'b1, 16'hF61E);
        drain();
        send(8'h92, 8'h17, 1'b0, 16'h0D1E);
        drain();

        send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        send(8'h80, 8'h80, 1'b1, 16'h4000);
        send(8'hFF, 8'hFF, 1'b1, 16'h0001);
        send(8'h00, 8'hA5, 1'b0, 16'h0000);
        send(8'h00, 8'hA5, 1'b1, 16'h0000);
        drain();

        bp_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
                    send(ra, rb, rs, 16'(ref_prod(32'(ra), 32'(rb), rs, 8)));
                end
            end
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        bp_phase = 1'b0;

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ra = 8'(i * 37 + 5); rb = 8'(i * 11 + 3); rs = 1'(i);
                    send(ra, rb, rs, 16'(ref_prod(32'(ra), 32'(rb), rs, 8)));
                end
            end
            begin
                repeat (7) @(posedge clk);
                #3;
                check("pre_reset_out_valid", 64'(out_valid), 1);
                rst = 1'b1;
                #1;
                check("async_reset_out_valid", 64'(out_valid), 0);
                check("async_reset_out_p", 64'(out_p), 0);
                exp_q.delete();
            end
        join
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send(8'h03, 8'h05, 1'b0, 16'h000F);
        send(8'hFE, 8'h03, 1'b1, 16'hFFFA);
        drain();

        for (int i = 0; i < 10000 && sweep_done < 12; i++) @(posedge clk);
        check("sweep_finished", 64'(sweep_done), 12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        sweep_rst = 1'b0;
        #2 sweep_rst = 1'b1;
        #20 sweep_rst = 1'b0;
    end

    for (genvar wi = 0; wi < 4; wi++) begin : g_w
        for (genvar ri = 0; ri < 3; ri++) begin : g_r
            localparam int W  = (wi == 0) ? 4 : (wi == 1) ? 8 : (wi == 2) ? 13 : 16;
            localparam int R  = (ri == 0) ? 1 : (ri == 1) ? 3 : W;
            localparam int SL = (W + R - 1) / R + 1;

            logic           s_in_valid;
            logic           s_in_ready;
            logic [W-1:0]   s_a;
            logic [W-1:0]   s_b;
            logic           s_in_signed;
            logic           s_out_valid;
            logic [2*W-1:0] s_p;
            logic           s_out_signed;
            logic [63:0]    s_exp;
            sb_t            q [$];

            pipelined_mult #(.WIDTH(W), .ROWS_PER_STAGE(R)) u_dut (
                .clk        (clk),
                .rst        (sweep_rst),
                .in_valid   (s_in_valid),
                .in_ready   (s_in_ready),
                .in_a       (s_a),
                .in_b       (s_b),
                .in_signed  (s_in_signed),
                .out_valid  (s_out_valid),
                .out_ready  (1'b1),
                .out_p      (s_p),
                .out_signed (s_out_signed)
            );

            initial begin
                s_in_valid = 1'b0; s_a = '0; s_b = '0; s_in_signed = 1'b0; s_exp = '0;
                @(negedge sweep_rst);
                @(posedge clk); #1;
                for (int n = 0; n < 2000; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        s_in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    s_a = W'(pick(W));
                    s_b = W'(pick(W));
                    s_in_signed = 1'($urandom);
                    s_exp = ref_prod(32'(s_a), 32'(s_b), s_in_signed, W);
                    s_in_valid = 1'b1;
                    @(posedge clk); #1;
                end
                s_in_valid = 1'b0;
                repeat (SL + 4) @(posedge clk);
                check($sformatf("sweep_drain_w%0d_r%0d", W, R), 64'(q.size()), 0);
                sweep_done++;
            end

            always @(negedge clk) begin
                if (!sweep_rst && s_in_valid && s_in_ready)
                    q.push_back('{s_exp, s_in_signed, cycle, 1'b1});
            end

            always @(negedge clk) begin
                if (!sweep_rst && s_out_valid) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sweep_unexpected_w%0d_r%0d: got %0h, expected no output",
                                 W, R, s_p);
                    end else begin
                        check($sformatf("sweep_p_w%0d_r%0d", W, R), 64'(s_p), q[0].p);
                        check($sformatf("sweep_sgn_w%0d_r%0d", W, R), 64'(s_out_signed),
                              64'(q[0].s));
                        check($sformatf("sweep_lat_w%0d_r%0d", W, R), 64'(cycle - q[0].cyc),
                              64'(SL));
                        q.delete(0);
                    end
                end
            end
        end
    end

endmodule
